// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed radix-4 Booth multiplier, one multiplier bit-pair per clock
module booth_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] Mulresult
);
   localparam int ITER = WIDTH / 2;
   localparam int CW = $clog2(ITER + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic signed [WIDTH+1:0] mcand, acc, addend, acc_sum;
   logic [WIDTH:0] mult;
   logic [CW-1:0] cnt;
   logic [2:0] t;
   logic last, accept;
   logic signed [2*WIDTH+2:0] shifted;
   always_comb begin
      t = mult[2:0];
      addend = (t == 3'b001 || t == 3'b010) ? mcand :
               (t == 3'b011) ? (mcand <<< 1) :
               (t == 3'b100) ? -(mcand <<< 1) :
               (t == 3'b101 || t == 3'b110) ? -mcand : '0;
      acc_sum = acc + addend;
      shifted = $signed({acc_sum, mult}) >>> 2;
      last = cnt == CW'(ITER - 1);
      accept = start && state != RUN;
      state_nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
      busy = state == RUN;
      done = state == DONE;
   end
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         mcand <= '0;
         acc <= '0;
         mult <= '0;
         cnt <= '0;
         Mulresult <= '0;
      end else if (accept) begin
         mcand <= {{2{A[WIDTH-1]}}, A};
         mult <= {B, 1'b0};
         acc <= '0;
         cnt <= '0;
      end else if (state == RUN) begin
         acc <= shifted[2*WIDTH+2:WIDTH+1];
         mult <= shifted[WIDTH:0];
         cnt <= cnt + CW'(1);
         if (last) Mulresult <= shifted[2*WIDTH:1];
      end
   end
endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential signed multiplier; the inverse-operation companion to the combinational divider in the ALU.
- Uses radix-4 Booth (bit-pair) recoding: one multiplier bit-pair per clock.
- Produces a 2*WIDTH product in the same HI/LO packing the divider uses: HI = [2W-1:W], LO = [W-1:0].
- The control unit starts it with a pulse and waits for done before writing HI/LO.

Parameters:
- WIDTH, 32, operand width in bits. Must be even. Iteration count ITER = WIDTH/2.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; operands are sampled on the edge where start is accepted
- A  input  WIDTH  multiplicand, two's complement
- B  input  WIDTH  multiplier, two's complement
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; Mulresult is valid from this cycle on
- Mulresult  output  2*WIDTH  signed product; [2W-1:W] = HI, [W-1:0] = LO

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named clock and reset.
- Reset values: busy=0, done=0, Mulresult=0, state=IDLE, iteration counter=0, internal accumulator=0.
- Reset has priority over every other input. Asserting it mid-operation aborts the operation: no done pulse, Mulresult=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch A into mcand (sign-extended to W+2 bits).
  - Latch {B,1'b0} into the multiplier shift register.
  - Clear the accumulator and counter; go to RUN.
- RUN:
  - Each edge examines triplet t = {m[2],m[1],m[0]} of the shift register.
  - Adds to the accumulator upper part: 000/111 → 0; 001/010 → +mcand; 011 → +2*mcand; 100 → −2*mcand; 101/110 → −mcand.
  - Then arithmetic-shifts the {accumulator, multiplier} pair right by 2 and increments the counter.
  - After ITER iterations (edges k+1 .. k+16 for W=32), the edge k+16 loads Mulresult and enters DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge: if start=1, accept new operands and go to RUN (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- busy=1 exactly in RUN. With W=32, busy is high for 16 cycles.
- Latency: done is visible 16 cycles after the accepting edge. Throughput: one product per 17 cycles when back-to-back.
- start while RUN is ignored. The operation in flight is unaffected, and the request is not queued.
- A and B may change freely after the accepting edge. Only the latched copies are used.
- Mulresult changes only on the edge entering DONE, or on reset. Otherwise it holds its value indefinitely (through IDLE and through the next RUN).
- Width rules:
  - The accumulator is W+2 bits signed, so ±2*mcand never overflows.
  - The final product is the low 2W bits of {accumulator, multiplier} after the last shift.
  - The result is the exact signed product for all inputs, including −2^(W−1) × −2^(W−1).
- No unsigned mode. The control unit handles unsigned operands externally if ever needed.

Test Plan:
- Reset, then A=3, B=4, pulse start → busy high 16 cycles, done one pulse, Mulresult=0x0000_0000_0000_000C.
- A=0xFFFF_FFFF, B=0xFFFF_FFFF (−1×−1) → 0x0000_0000_0000_0001. Then A=0x7FFF_FFFF, B=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0001.
- A=B=0x8000_0000 → 0x4000_0000_0000_0000. Then A=0x8000_0000, B=0x7FFF_FFFF → 0xC000_0000_8000_0000.
- Start accepted with A=5, B=7; toggle A/B and pulse start again during RUN → single done pulse 16 cycles after the first start, Mulresult=35, no second operation.
- Start A=−6 (0xFFFF_FFFA), B=9, then reset at cycle 8 → busy=0, done never pulses, Mulresult=0. Restart → 0xFFFF_FFFF_FFFF_FFCA (−54).
- Back-to-back: start held high in the DONE cycle with A=12345, B=−1 after a previous op → second done pulse exactly 17 cycles after the first; Mulresult=0xFFFF_FFFF_FFFF_CFC7. A random-operand sweep of ≥1000 pairs matches the signed 64-bit reference product.
